date_set_ctrl: RTL

DATE_SET_CTRL -- requirements
Module: date_set_ctrl

---
 rtl/date_set_pkg.sv | 34 +++
 rtl/date_set_ctrl_month_length.sv | 42 ++++
 rtl/date_set_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/date_set_pkg.sv
// Shared encodings for the date-setting controller: FSM states, edit-field codes, month constants.
// Types and helpers only; no timing or flow-control behaviour lives here.
package date_set_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDIT_DAY,
    S_EDIT_MONTH,
    S_EDIT_YEAR,
    S_COMMIT
  } state_t;

  typedef enum logic [1:0] {
    FLD_NONE  = 2'd0,
    FLD_DAY   = 2'd1,
    FLD_MONTH = 2'd2,
    FLD_YEAR  = 2'd3
  } field_t;

  localparam logic [3:0] MON_JAN = 4'd1;
  localparam logic [3:0] MON_FEB = 4'd2;
  localparam logic [3:0] MON_APR = 4'd4;
  localparam logic [3:0] MON_JUN = 4'd6;
  localparam logic [3:0] MON_SEP = 4'd9;
  localparam logic [3:0] MON_NOV = 4'd11;
  localparam logic [3:0] MON_DEC = 4'd12;

  localparam logic [4:0] DAY_MIN = 5'd1;

  function automatic logic month_valid(input logic [3:0] m);
    return (m >= MON_JAN) && (m <= MON_DEC);
  endfunction

endpackage

// File: rtl/date_set_ctrl_month_length.sv
// Days in a month for the given month/year; purely combinational, no handshake.
// Leap rule: 2-bit (year[1:0]==0) by default, full Gregorian on year+YEAR_BASE with DATE_SET_GREGORIAN_EN.
module month_length
  import date_set_pkg::*;
#(
  parameter int YEARRES   = 12,
  parameter int YEAR_BASE = 2000
) (
  input  logic [3:0]         month,
  input  logic [YEARRES-1:0] year,
  output logic [4:0]         days
);

  logic leap;

`ifdef DATE_SET_GREGORIAN_EN
  int full_year;

  always_comb begin
    full_year = int'(year) + YEAR_BASE;
    leap      = ((full_year % 4) == 0) &&
                (((full_year % 100) != 0) || ((full_year % 400) == 0));
  end
`else
  assign leap = (year[1:0] == 2'b00);

  // The short rule only matches the real calendar when the base year starts a leap cycle.
  if ((YEAR_BASE % 4) != 0) begin : g_base_chk
    $warning("month_length: YEAR_BASE not a multiple of 4, 2-bit leap rule is offset");
  end
`endif

  always_comb begin
    days = 5'd31;
    case (month)
      MON_FEB:                            days = leap ? 5'd29 : 5'd28;
      MON_APR, MON_JUN, MON_SEP, MON_NOV: days = 5'd30;
      default:                            days = 5'd31;
    endcase
  end

endmodule

// File: rtl/date_set_ctrl.sv
// Button-driven date editor: shadows date_cur, edits day/month/year, emits a one-cycle date_ow from a flop on commit.
// No backpressure; buttons are single-cycle pulses, idle edits abort after TIMEOUT_CYC cycles. Leap rule via DATE_SET_GREGORIAN_EN.
module date_set_ctrl
  import date_set_pkg::*;
#(
  parameter int YEARRES     = 12,
  parameter int YEAR_BASE   = 2000,
  parameter int TIMEOUT_CYC = 100000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_mode,
  input  logic               btn_inc,
  input  logic               btn_dec,
  input  logic [YEARRES+8:0] date_cur,
  output logic [YEARRES+8:0] date_new,
  output logic               date_ow,
  output logic               editing,
  output logic [1:0]         edit_field
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_t             state, state_nx;
  field_t             fld;
  logic [4:0]         sh_day, cur_day, dim;
  logic [3:0]         sh_mon, cur_mon;
  logic [YEARRES-1:0] sh_year, cur_year;
  logic [CW-1:0]      idle_cnt;
  logic               clamp_pend;
  logic               any_btn, inc_ev, dec_ev, in_edit, tmo, load;

  assign {cur_day, cur_mon, cur_year} = date_cur;
  assign date_new   = {sh_day, sh_mon, sh_year};
  assign edit_field = fld;

  assign any_btn = btn_mode | btn_inc | btn_dec;
  assign inc_ev  = btn_inc & ~btn_dec & ~btn_mode;
  assign dec_ev  = btn_dec & ~btn_inc & ~btn_mode;
  assign in_edit = (state == S_EDIT_DAY) || (state == S_EDIT_MONTH) || (state == S_EDIT_YEAR);
  assign tmo     = in_edit && !any_btn && (idle_cnt == CW'(TIMEOUT_CYC - 1));
  assign load    = (state == S_IDLE) && btn_mode;

  month_length #(
    .YEARRES  (YEARRES),
    .YEAR_BASE(YEAR_BASE)
  ) u_month_length (
    .month(sh_mon),
    .year (sh_year),
    .days (dim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      date_ow <= 1'b0;
    end else begin
      state   <= state_nx;
      date_ow <= (state_nx == S_COMMIT);
    end
  end

  always_comb begin
    state_nx = state;
    editing  = 1'b0;
    fld      = FLD_NONE;
    case (state)
      S_IDLE: if (btn_mode) state_nx = S_EDIT_DAY;
      S_EDIT_DAY: begin
        editing = 1'b1;
        fld     = FLD_DAY;
        if (tmo)           state_nx = S_IDLE;
        else if (btn_mode) state_nx = S_EDIT_MONTH;
      end
      S_EDIT_MONTH: begin
        editing = 1'b1;
        fld     = FLD_MONTH;
        if (tmo)           state_nx = S_IDLE;
        else if (btn_mode) state_nx = S_EDIT_YEAR;
      end
      S_EDIT_YEAR: begin
        editing = 1'b1;
        fld     = FLD_YEAR;
        if (tmo)           state_nx = S_IDLE;
        else if (btn_mode) state_nx = S_COMMIT;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (!in_edit || any_btn || tmo) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CW'(1);
    end
  end

  // Day clamps a cycle after month/year moves, once dim reflects the new shadow values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_day     <= '0;
      sh_mon     <= '0;
      sh_year    <= '0;
      clamp_pend <= 1'b0;
    end else begin
      clamp_pend <= 1'b0;

      if (load) begin
        sh_day <= (cur_day == 5'd0) ? DAY_MIN : cur_day;
      end else if (clamp_pend && (sh_day > dim)) begin
        sh_day <= dim;
      end else if (state == S_EDIT_DAY) begin
        if (inc_ev)      sh_day <= (sh_day >= dim) ? DAY_MIN : sh_day + 5'd1;
        else if (dec_ev) sh_day <= (sh_day <= DAY_MIN) ? dim : sh_day - 5'd1;
      end

      if (load) begin
        sh_mon  <= month_valid(cur_mon) ? cur_mon : MON_JAN;
        sh_year <= cur_year;
      end else if (state == S_EDIT_MONTH) begin
        if (inc_ev) begin
          sh_mon     <= (sh_mon >= MON_DEC) ? MON_JAN : sh_mon + 4'd1;
          clamp_pend <= 1'b1;
        end else if (dec_ev) begin
          sh_mon     <= (sh_mon <= MON_JAN) ? MON_DEC : sh_mon - 4'd1;
          clamp_pend <= 1'b1;
        end
      end else if (state == S_EDIT_YEAR) begin
        if (inc_ev) begin
          sh_year    <= sh_year + YEARRES'(1);
          clamp_pend <= 1'b1;
        end else if (dec_ev) begin
          sh_year    <= sh_year - YEARRES'(1);
          clamp_pend <= 1'b1;
        end
      end
    end
  end

endmodule
